// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared FSM state encoding and forward-select codes.
// Revision    : 1.0
// ============================================================================
package hazard_pkg;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_MEM = 2'b01;
    localparam fwd_sel_t FWD_WB  = 2'b10;

    localparam logic [1:0] ST_IDLE     = 2'b00;
    localparam logic [1:0] ST_MEM_WAIT = 2'b01;
    localparam logic [1:0] ST_ERROR    = 2'b10;

endpackage
`default_nettype wire

// File: rtl/fwd_sel.sv
`default_nettype none
// ============================================================================
// Module      : fwd_sel
// Description : Single-operand forward select, MEM result preferred over WB.
// Revision    : 1.0
// ============================================================================
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] reg_src,
    input  logic [4:0] reg_dest_mem,
    input  logic       reg_write_mem,
    input  logic [4:0] reg_dest_wb,
    input  logic       reg_write_wb,
    output logic [1:0] sel
);

    logic w_hit_mem;
    logic w_hit_wb;

    // x0 is hardwired zero, so a write to it never produces a forwardable value
    assign w_hit_mem = reg_write_mem && (reg_dest_mem != 5'd0) && (reg_dest_mem == reg_src);
    assign w_hit_wb  = reg_write_wb  && (reg_dest_wb  != 5'd0) && (reg_dest_wb  == reg_src);

    assign sel = w_hit_mem ? FWD_MEM : (w_hit_wb ? FWD_WB : FWD_RF);

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard unit: forwarding, load-use, redirect, memory
//               stall with timeout, and stall/flush performance counters.
// Revision    : 1.0
// ============================================================================
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  reg1_src_ID,
    input  logic [4:0]  reg2_src_ID,
    input  logic [4:0]  reg1_src_EX,
    input  logic [4:0]  reg2_src_EX,
    input  logic [4:0]  reg_dest_EX,
    input  logic [4:0]  reg_dest_MEM,
    input  logic [4:0]  reg_dest_WB,
    input  logic        mem_read_EX,
    input  logic        reg_write_MEM,
    input  logic        reg_write_WB,
    input  logic        br_taken_EX,
    input  logic        dmem_req_MEM,
    input  logic        dmem_ack,
    output logic        bubbleF,
    output logic        bubbleD,
    output logic        bubbleE,
    output logic        bubbleM,
    output logic        bubbleW,
    output logic        flushD,
    output logic        flushE,
    output logic        flushM,
    output logic        flushW,
    output logic [1:0]  op1_sel,
    output logic [1:0]  op2_sel,
    output logic        mem_err,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    localparam int c_WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    logic [1:0]          r_state;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic                r_mem_err;
    logic [31:0]         r_stall_cnt;
    logic [31:0]         r_flush_cnt;

    logic [1:0] w_op1_sel;
    logic [1:0] w_op2_sel;
    logic       w_err;
    logic       w_mem_stall;
    logic       w_load_use;
    logic       w_timeout;

    fwd_sel u_fwd_op1 (
        .reg_src       (reg1_src_EX),
        .reg_dest_mem  (reg_dest_MEM),
        .reg_write_mem (reg_write_MEM),
        .reg_dest_wb   (reg_dest_WB),
        .reg_write_wb  (reg_write_WB),
        .sel           (w_op1_sel)
    );

    fwd_sel u_fwd_op2 (
        .reg_src       (reg2_src_EX),
        .reg_dest_mem  (reg_dest_MEM),
        .reg_write_mem (reg_write_MEM),
        .reg_dest_wb   (reg_dest_WB),
        .reg_write_wb  (reg_write_WB),
        .sel           (w_op2_sel)
    );

    assign op1_sel = rst_n ? w_op1_sel : FWD_RF;
    assign op2_sel = rst_n ? w_op2_sel : FWD_RF;

    assign w_err       = (r_state == ST_ERROR);
    assign w_mem_stall = !w_err && dmem_req_MEM && !dmem_ack;
    assign w_load_use  = mem_read_EX && (reg_dest_EX != 5'd0) &&
                         ((reg_dest_EX == reg1_src_ID) || (reg_dest_EX == reg2_src_ID));
    assign w_timeout   = (32'(r_wait_cnt) + 32'd1) >= 32'(MEM_TIMEOUT);

    // Priority: error, memory stall, redirect, load-use; all quiet in reset
    always_comb begin
        bubbleF = 1'b0;
        bubbleD = 1'b0;
        bubbleE = 1'b0;
        bubbleM = 1'b0;
        bubbleW = 1'b0;
        flushD  = 1'b0;
        flushE  = 1'b0;
        flushM  = 1'b0;
        flushW  = 1'b0;
        if (rst_n) begin
            if (w_err) begin
                bubbleF = 1'b1;
                bubbleD = 1'b1;
                bubbleE = 1'b1;
                bubbleM = 1'b1;
                bubbleW = 1'b1;
            end else if (w_mem_stall) begin
                bubbleF = 1'b1;
                bubbleD = 1'b1;
                bubbleE = 1'b1;
                bubbleM = 1'b1;
                flushW  = 1'b1;
            end else if (br_taken_EX) begin
                flushD = 1'b1;
                flushE = 1'b1;
            end else if (w_load_use) begin
                bubbleF = 1'b1;
                bubbleD = 1'b1;
                flushE  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_mem_stall) begin
                        r_state    <= ST_MEM_WAIT;
                        r_wait_cnt <= '0;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!w_mem_stall) begin
                        r_state <= ST_IDLE;
                    end else if (w_timeout) begin
                        r_state   <= ST_ERROR;
                        r_mem_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: begin
                    // Only reset leaves ERROR; an illegal encoding is treated as ERROR
                    r_state   <= ST_ERROR;
                    r_mem_err <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (bubbleF && !w_err) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (flushD) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign mem_err   = r_mem_err;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed self-checking bench for hazard_ctrl (MEM_TIMEOUT=4).
// Revision    : 1.0
// ============================================================================
module tb_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic [4:0]  reg1_src_ID, reg2_src_ID, reg1_src_EX, reg2_src_EX;
    logic [4:0]  reg_dest_EX, reg_dest_MEM, reg_dest_WB;
    logic        mem_read_EX, reg_write_MEM, reg_write_WB, br_taken_EX;
    logic        dmem_req_MEM, dmem_ack;
    logic        bubbleF, bubbleD, bubbleE, bubbleM, bubbleW;
    logic        flushD, flushE, flushM, flushW;
    logic [1:0]  op1_sel, op2_sel;
    logic        mem_err;
    logic [31:0] stall_cnt, flush_cnt;

    int checks;
    int passed;
    int exp_stall;
    int exp_flush;

    // {bubbleF,bubbleD,bubbleE,bubbleM,bubbleW,flushD,flushE,flushM,flushW}
    logic [8:0] ctrl;
    assign ctrl = {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW, flushD, flushE, flushM, flushW};

    localparam logic [8:0] C_NONE  = 9'b00000_0000;
    localparam logic [8:0] C_LU    = 9'b11000_0100;
    localparam logic [8:0] C_REDIR = 9'b00000_1100;
    localparam logic [8:0] C_MSTL  = 9'b11110_0001;
    localparam logic [8:0] C_ERR   = 9'b11111_0000;

    hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .reg1_src_ID   (reg1_src_ID),
        .reg2_src_ID   (reg2_src_ID),
        .reg1_src_EX   (reg1_src_EX),
        .reg2_src_EX   (reg2_src_EX),
        .reg_dest_EX   (reg_dest_EX),
        .reg_dest_MEM  (reg_dest_MEM),
        .reg_dest_WB   (reg_dest_WB),
        .mem_read_EX   (mem_read_EX),
        .reg_write_MEM (reg_write_MEM),
        .reg_write_WB  (reg_write_WB),
        .br_taken_EX   (br_taken_EX),
        .dmem_req_MEM  (dmem_req_MEM),
        .dmem_ack      (dmem_ack),
        .bubbleF       (bubbleF),
        .bubbleD       (bubbleD),
        .bubbleE       (bubbleE),
        .bubbleM       (bubbleM),
        .bubbleW       (bubbleW),
        .flushD        (flushD),
        .flushE        (flushE),
        .flushM        (flushM),
        .flushW        (flushW),
        .op1_sel       (op1_sel),
        .op2_sel       (op2_sel),
        .mem_err       (mem_err),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        reg1_src_ID = 5'd0; reg2_src_ID = 5'd0;
        reg1_src_EX = 5'd0; reg2_src_EX = 5'd0;
        reg_dest_EX = 5'd0; reg_dest_MEM = 5'd0; reg_dest_WB = 5'd0;
        mem_read_EX = 1'b0; reg_write_MEM = 1'b0; reg_write_WB = 1'b0;
        br_taken_EX = 1'b0; dmem_req_MEM = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        mem_read_EX = 1'b1; reg_dest_EX = 5'd3; reg1_src_ID = 5'd3;
        reg_write_MEM = 1'b1; reg_dest_MEM = 5'd4; reg1_src_EX = 5'd4; reg2_src_EX = 5'd4;
        br_taken_EX = 1'b1;
        #2;
        checks++; if (ctrl !== C_NONE) $display("FAIL reset_ctrl got=%b exp=%b", ctrl, C_NONE); else passed++;
        checks++; if ({op1_sel, op2_sel} !== 4'b0000) $display("FAIL reset_sel got=%b exp=0000", {op1_sel, op2_sel}); else passed++;
        checks++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0 || mem_err !== 1'b0)
            $display("FAIL reset_regs stall=%0d flush=%0d err=%b exp=0/0/0", stall_cnt, flush_cnt, mem_err); else passed++;
        tick();
        tick();
        clear_inputs();
        #1 rst_n = 1'b1;
        tick();
        exp_stall = 0;
        exp_flush = 0;
    endtask

    task automatic test_forward();
        clear_inputs();
        reg_write_MEM = 1'b1; reg_dest_MEM = 5'd5;
        reg_write_WB  = 1'b1; reg_dest_WB  = 5'd5;
        reg1_src_EX = 5'd5; reg2_src_EX = 5'd6;
        #1;
        checks++; if (op1_sel !== 2'b01) $display("FAIL fwd_mem_wins got=%b exp=01", op1_sel); else passed++;
        checks++; if (op2_sel !== 2'b00) $display("FAIL fwd_op2_none got=%b exp=00", op2_sel); else passed++;
        reg_dest_MEM = 5'd0;
        #1;
        checks++; if (op1_sel !== 2'b10) $display("FAIL fwd_mem_x0_wb got=%b exp=10", op1_sel); else passed++;
        reg_dest_MEM = 5'd6; reg_write_WB = 1'b0;
        #1;
        checks++; if ({op1_sel, op2_sel} !== 4'b0001) $display("FAIL fwd_op2_mem got=%b exp=0001", {op1_sel, op2_sel}); else passed++;
        reg_write_MEM = 1'b0; reg_write_WB = 1'b1; reg_dest_WB = 5'd0; reg1_src_EX = 5'd0;
        #1;
        checks++; if (op1_sel !== 2'b00) $display("FAIL fwd_x0_wb got=%b exp=00", op1_sel); else passed++;
        checks++; if (ctrl !== C_NONE) $display("FAIL fwd_no_ctrl got=%b exp=%b", ctrl, C_NONE); else passed++;
    endtask

    task automatic test_load_use();
        clear_inputs();
        mem_read_EX = 1'b1; reg_dest_EX = 5'd7; reg2_src_ID = 5'd7; reg1_src_ID = 5'd2;
        #1;
        checks++; if (ctrl !== C_LU) $display("FAIL load_use got=%b exp=%b", ctrl, C_LU); else passed++;
        tick();
        exp_stall++;
        checks++; if (stall_cnt !== 32'(exp_stall)) $display("FAIL load_use_cnt got=%0d exp=%0d", stall_cnt, exp_stall); else passed++;
        reg_dest_EX = 5'd0; reg1_src_ID = 5'd0; reg2_src_ID = 5'd0;
        #1;
        checks++; if (ctrl !== C_NONE) $display("FAIL load_use_x0 got=%b exp=%b", ctrl, C_NONE); else passed++;
        tick();
        checks++; if (stall_cnt !== 32'(exp_stall)) $display("FAIL load_use_x0_cnt got=%0d exp=%0d", stall_cnt, exp_stall); else passed++;
    endtask

    task automatic test_redirect();
        clear_inputs();
        mem_read_EX = 1'b1; reg_dest_EX = 5'd7; reg2_src_ID = 5'd7; br_taken_EX = 1'b1;
        #1;
        checks++; if (ctrl !== C_REDIR) $display("FAIL redirect got=%b exp=%b", ctrl, C_REDIR); else passed++;
        tick();
        exp_flush++;
        checks++; if (flush_cnt !== 32'(exp_flush) || stall_cnt !== 32'(exp_stall))
            $display("FAIL redirect_cnt flush=%0d stall=%0d exp=%0d/%0d", flush_cnt, stall_cnt, exp_flush, exp_stall); else passed++;
    endtask

    task automatic test_mem_stall();
        clear_inputs();
        dmem_req_MEM = 1'b1;
        mem_read_EX = 1'b1; reg_dest_EX = 5'd9; reg1_src_ID = 5'd9;
        for (int i = 0; i < 3; i++) begin
            br_taken_EX = (i == 1);
            #1;
            checks++; if (ctrl !== C_MSTL) $display("FAIL mem_stall_%0d got=%b exp=%b", i, ctrl, C_MSTL); else passed++;
            tick();
            exp_stall++;
        end
        dmem_ack = 1'b1; br_taken_EX = 1'b1;
        #1;
        checks++; if (ctrl !== C_REDIR) $display("FAIL mem_ack_cycle got=%b exp=%b", ctrl, C_REDIR); else passed++;
        tick();
        exp_flush++;
        checks++; if (stall_cnt !== 32'(exp_stall) || flush_cnt !== 32'(exp_flush))
            $display("FAIL mem_stall_cnt stall=%0d flush=%0d exp=%0d/%0d", stall_cnt, flush_cnt, exp_stall, exp_flush); else passed++;
        clear_inputs();
        dmem_ack = 1'b1;
        #1;
        checks++; if (ctrl !== C_NONE) $display("FAIL ack_no_req got=%b exp=%b", ctrl, C_NONE); else passed++;
        tick();
    endtask

    task automatic test_timeout();
        clear_inputs();
        dmem_req_MEM = 1'b1;
        // One IDLE cycle plus four MEM_WAIT cycles before ERROR
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (ctrl !== C_MSTL || mem_err !== 1'b0)
                $display("FAIL timeout_wait_%0d got=%b err=%b exp=%b err=0", i, ctrl, mem_err, C_MSTL); else passed++;
            tick();
            exp_stall++;
        end
        checks++; if (ctrl !== C_ERR || mem_err !== 1'b1)
            $display("FAIL timeout_error got=%b err=%b exp=%b err=1", ctrl, mem_err, C_ERR); else passed++;
        checks++; if (stall_cnt !== 32'(exp_stall)) $display("FAIL timeout_cnt got=%0d exp=%0d", stall_cnt, exp_stall); else passed++;
        dmem_ack = 1'b1; br_taken_EX = 1'b1;
        tick();
        tick();
        checks++; if (ctrl !== C_ERR || mem_err !== 1'b1 || stall_cnt !== 32'(exp_stall) || flush_cnt !== 32'(exp_flush))
            $display("FAIL error_sticky got=%b err=%b stall=%0d flush=%0d", ctrl, mem_err, stall_cnt, flush_cnt); else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ctrl !== C_NONE || mem_err !== 1'b0 || stall_cnt !== 32'd0 || flush_cnt !== 32'd0)
            $display("FAIL error_reset got=%b err=%b stall=%0d flush=%0d exp=0", ctrl, mem_err, stall_cnt, flush_cnt); else passed++;
        tick();
        clear_inputs();
        dmem_ack = 1'b1;
        #1 rst_n = 1'b1;
        tick();
        checks++; if (ctrl !== C_NONE || mem_err !== 1'b0 || stall_cnt !== 32'd0)
            $display("FAIL post_reset_idle got=%b err=%b stall=%0d", ctrl, mem_err, stall_cnt); else passed++;
        dmem_req_MEM = 1'b1; dmem_ack = 1'b0;
        #1;
        checks++; if (ctrl !== C_MSTL) $display("FAIL post_reset_stall got=%b exp=%b", ctrl, C_MSTL); else passed++;
        tick();
        checks++; if (stall_cnt !== 32'd1 || mem_err !== 1'b0)
            $display("FAIL post_reset_cnt stall=%0d err=%b exp=1/0", stall_cnt, mem_err); else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        exp_stall = 0;
        exp_flush = 0;
        test_reset();
        test_forward();
        test_load_use();
        test_redirect();
        test_mem_stall();
        test_timeout();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
